// File: rtl/corr_sample_loader_if.sv
// Handshake, read-port and status bundle between the correlator sample loader
// and its producer/consumer. The master drives the inputs; the slave is the loader.
interface corr_sample_loader_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              load_start;
    logic [1:0]        n_sel;
    logic              in_valid;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              buf_ready;
    logic [ADDR_W:0]   fill_count;
    logic [ADDR_W:0]   n_target;
    logic              ovf_err;

    modport master (
        output load_start, n_sel, in_valid, in_a, in_b, rd_addr,
        input  in_ready, rd_a, rd_b, buf_ready, fill_count, n_target, ovf_err
    );

    modport slave (
        input  load_start, n_sel, in_valid, in_a, in_b, rd_addr,
        output in_ready, rd_a, rd_b, buf_ready, fill_count, n_target, ovf_err
    );
endinterface

// File: rtl/corr_sample_loader.sv
// Writer side of the correlator A/B sample store: loads n_target sample pairs
// over valid/ready, then freezes them behind buf_ready with a registered read port.
module corr_sample_loader #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input logic                clk,
    input logic                reset,
    corr_sample_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W:0]   fill_count_r;
    logic [ADDR_W:0]   n_target_r;
    logic              buf_ready_r;
    logic              ovf_err_r;
    logic [DEPTH-1:0]  valid_r;
    logic [DATA_W-1:0] rd_a_r;
    logic [DATA_W-1:0] rd_b_r;
    logic [DATA_W-1:0] mem_a_r [DEPTH];
    logic [DATA_W-1:0] mem_b_r [DEPTH];

    logic              in_ready_s;
    logic              xfer_s;
    logic              ovf_hit_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W:0]   fill_next_s;

    // Target count 1/2/4/8, clipped to the buffer depth.
    function automatic logic [ADDR_W:0] decode_n(input logic [1:0] sel);
        logic [31:0] n_v;
        n_v = 32'd1 << sel;
        if (n_v > 32'(DEPTH)) begin
            n_v = 32'(DEPTH);
        end else begin
            n_v = n_v;
        end
        return n_v[ADDR_W:0];
    endfunction

    // Handshake decode; a load_start cycle never accepts a pair.
    always_comb begin
        in_ready_s  = 1'b0;
        if ((state_r == ST_LOAD) && !bus.load_start) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        xfer_s      = in_ready_s && bus.in_valid;
        ovf_hit_s   = bus.in_valid && !in_ready_s;
        wr_addr_s   = fill_count_r[ADDR_W-1:0];
        fill_next_s = fill_count_r + {{ADDR_W{1'b0}}, 1'b1};
    end

    // Load control FSM with fill/target/status registers and per-entry valid bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            fill_count_r <= '0;
            n_target_r   <= '0;
            buf_ready_r  <= 1'b0;
            ovf_err_r    <= 1'b0;
            valid_r      <= '0;
        end else begin
            // A pair offered alongside load_start still counts as an overflow.
            if (ovf_hit_s) begin
                ovf_err_r <= 1'b1;
            end else if (bus.load_start) begin
                ovf_err_r <= 1'b0;
            end else begin
                ovf_err_r <= ovf_err_r;
            end

            if (bus.load_start) begin
                state_r      <= ST_LOAD;
                fill_count_r <= '0;
                valid_r      <= '0;
                n_target_r   <= decode_n(bus.n_sel);
                buf_ready_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        if (xfer_s) begin
                            valid_r[wr_addr_s] <= 1'b1;
                            fill_count_r       <= fill_next_s;
                            if (fill_next_s == n_target_r) begin
                                state_r     <= ST_READY;
                                buf_ready_r <= 1'b1;
                            end
                        end
                    end
                    ST_READY: begin
                        state_r <= ST_READY;
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        buf_ready_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sample storage; contents are only visible through the valid bits.
    always_ff @(posedge clk) begin
        if (xfer_s) begin
            mem_a_r[wr_addr_s] <= bus.in_a;
            mem_b_r[wr_addr_s] <= bus.in_b;
        end
    end

    // Registered read port; same-address write in this cycle returns the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_a_r <= '0;
            rd_b_r <= '0;
        end else if (valid_r[bus.rd_addr]) begin
            rd_a_r <= mem_a_r[bus.rd_addr];
            rd_b_r <= mem_b_r[bus.rd_addr];
        end else begin
            rd_a_r <= '0;
            rd_b_r <= '0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.rd_a       = rd_a_r;
    assign bus.rd_b       = rd_b_r;
    assign bus.buf_ready  = buf_ready_r;
    assign bus.fill_count = fill_count_r;
    assign bus.n_target   = n_target_r;
    assign bus.ovf_err    = ovf_err_r;

endmodule
